// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: coordinate widths,
// apple-placement LFSR constants, retry limit and placement FSM encoding.
package snake_pkg;

    localparam int X_W = 7;
    localparam int Y_W = 6;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a mask over bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int RETRY_W     = 6;
    localparam int RETRY_LIMIT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GEN    = 2'd1,
        ST_PLACED = 2'd2
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a nonzero seed on a maximal-length
// polynomial guarantees the state never reaches zero.
module lfsr16
    import snake_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/apple_gen.sv
// Apple placement for the snake game: draws random candidates from an LFSR,
// rejects ones off-grid or under the head, and reports when the apple is eaten.
module apple_gen
    import snake_pkg::*;
(
    input  logic           pclk,
    input  logic           rst,
    input  logic           game_start,
    input  logic [X_W-1:0] grid_cols,
    input  logic [Y_W-1:0] grid_rows,
    input  logic [X_W-1:0] head_x,
    input  logic [Y_W-1:0] head_y,
    input  logic           head_valid,
    output logic [X_W-1:0] apple_x,
    output logic [Y_W-1:0] apple_y,
    output logic           apple_valid,
    output logic           apple_eaten,
    output logic           busy
);

    logic [15:0]        lfsr;
    state_t             fsm_state, fsm_next;
    logic [RETRY_W-1:0] retry, retry_next;
    logic               retry_done, retry_done_next;
    logic [X_W-1:0]     x_next, cand_x;
    logic [Y_W-1:0]     y_next, cand_y;
    logic               eaten_next, cand_ok, eat_hit, head_at_origin;

    lfsr16 u_lfsr (
        .pclk  (pclk),
        .rst   (rst),
        .state (lfsr)
    );

    assign cand_x = lfsr[X_W-1:0];
    assign cand_y = lfsr[8 +: Y_W];
    assign cand_ok = (cand_x != '0) && (cand_x <= grid_cols) &&
                     (cand_y != '0) && (cand_y <= grid_rows) &&
                     !((cand_x == head_x) && (cand_y == head_y));
    assign eat_hit = head_valid && (head_x == apple_x) && (head_y == apple_y);
    assign head_at_origin = (head_x == X_W'(1)) && (head_y == Y_W'(1));

    // retry_done marks the 64th rejection so the fallback lands one cycle later
    always_comb begin
        fsm_next        = fsm_state;
        retry_next      = retry;
        retry_done_next = retry_done;
        x_next          = apple_x;
        y_next          = apple_y;
        eaten_next      = 1'b0;
        case (fsm_state)
            ST_IDLE: begin
                if (game_start && (grid_cols != '0) && (grid_rows != '0)) begin
                    fsm_next        = ST_GEN;
                    retry_next      = '0;
                    retry_done_next = 1'b0;
                end
            end
            ST_GEN: begin
                if (game_start) begin
                    retry_next      = '0;
                    retry_done_next = 1'b0;
                end else if (retry_done) begin
                    fsm_next = ST_PLACED;
                    x_next   = head_at_origin ? grid_cols : X_W'(1);
                    y_next   = head_at_origin ? grid_rows : Y_W'(1);
                end else if (cand_ok) begin
                    fsm_next = ST_PLACED;
                    x_next   = cand_x;
                    y_next   = cand_y;
                end else begin
                    retry_next = retry + RETRY_W'(1);
                    if (retry == RETRY_W'(RETRY_LIMIT - 1)) begin
                        retry_done_next = 1'b1;
                    end
                end
            end
            ST_PLACED: begin
                if (game_start || eat_hit) begin
                    fsm_next        = ST_GEN;
                    retry_next      = '0;
                    retry_done_next = 1'b0;
                    eaten_next      = !game_start;
                end
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            fsm_state   <= ST_IDLE;
            retry       <= '0;
            retry_done  <= 1'b0;
            apple_x     <= '0;
            apple_y     <= '0;
            apple_valid <= 1'b0;
            apple_eaten <= 1'b0;
            busy        <= 1'b0;
        end else begin
            fsm_state   <= fsm_next;
            retry       <= retry_next;
            retry_done  <= retry_done_next;
            apple_x     <= x_next;
            apple_y     <= y_next;
            apple_valid <= (fsm_next == ST_PLACED);
            apple_eaten <= eaten_next;
            busy        <= (fsm_next == ST_GEN);
        end
    end

endmodule

// File: doc/apple_gen.md
APPLE_GEN -- requirements
Module: apple_gen

Interface
REQ-001 The module SHALL have these ports (name  direction  width  meaning):
- pclk  input  1  pixel clock; sole clock
- rst  input  1  asynchronous, active-high reset
- game_start  input  1  one-cycle pulse; start or restart apple placement
- grid_cols  input  7  playfield width in cells; legal x is 1..grid_cols
- grid_rows  input  6  playfield height in cells; legal y is 1..grid_rows
- head_x  input  7  snake head column, 1-based
- head_y  input  6  snake head row, 1-based
- head_valid  input  1  one-cycle pulse; head_x/head_y hold a new head position
- apple_x  output  7  apple column, 1-based; feeds draw stage
- apple_y  output  6  apple row, 1-based; feeds draw stage
- apple_valid  output  1  apple_x/apple_y hold a placed apple
- apple_eaten  output  1  one-cycle pulse; head landed on apple
- busy  output  1  placement in progress
REQ-002 The module SHALL use one clock, pclk; reset rst SHALL be asynchronous and active-high.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 A 16-bit Fibonacci LFSR (taps 16,14,13,11, shift left, feedback into bit 0) SHALL advance every pclk cycle in every state.
REQ-005 The candidate SHALL be x = lfsr[6:0], y = lfsr[13:8].
REQ-006 The FSM SHALL have states IDLE, GEN, PLACED.
REQ-007 IDLE -> GEN on game_start when grid_cols != 0 and grid_rows != 0; otherwise game_start SHALL be ignored.
REQ-008 GEN SHALL evaluate one candidate per cycle.
- Accept when 1 <= x <= grid_cols, 1 <= y <= grid_rows, and (x,y) != (head_x,head_y).
- On accept: load apple_x/apple_y in the same clock edge, set apple_valid=1, go to PLACED.
REQ-009 A 6-bit retry counter SHALL clear on GEN entry and increment per rejected candidate.
- After 64 rejections: place at (1,1), or at (grid_cols,grid_rows) if the head is at (1,1).
- Placement latency SHALL therefore never exceed 65 cycles from GEN entry.
REQ-010 In GEN: busy=1, apple_valid=0; apple_x/apple_y SHALL hold their previous values until accept.
REQ-011 In PLACED, on head_valid with (head_x,head_y) == (apple_x,apple_y):
- apple_eaten SHALL pulse high for exactly the next cycle.
- The FSM SHALL go to GEN.
REQ-012 head_valid with a non-matching head SHALL leave all outputs unchanged.
REQ-013 game_start in GEN or PLACED SHALL restart GEN: retry counter cleared, apple_valid=0, no apple_eaten pulse.
REQ-014 game_start coinciding with an eating head_valid SHALL take priority: restart GEN, no apple_eaten pulse.
REQ-015 grid_cols/grid_rows changing during GEN SHALL apply to the next candidate evaluated.
REQ-016 Comparisons SHALL be unsigned at port widths; no wrap of 1-based coordinates SHALL occur.

Reset
REQ-017 On rst the module SHALL enter IDLE with lfsr=16'hACE1, retry counter=0, apple_x=0, apple_y=0, apple_valid=0, apple_eaten=0, busy=0.
REQ-018 Reset asserted mid-GEN or mid-PLACED SHALL abort immediately; no apple_eaten pulse SHALL follow deassertion.
REQ-019 The LFSR SHALL never hold zero.

Structure
REQ-020 The shared package snake_pkg SHALL hold:
- coordinate widths (X_W=7, Y_W=6)
- LFSR seed and taps
- retry limit 64
- FSM state encoding
REQ-021 The LFSR SHALL be a sub-module named lfsr16, with ports pclk, rst, and a 16-bit state output.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, then game_start with grid 64x48 -> apple_valid rises within 65 cycles; 1<=apple_x<=64, 1<=apple_y<=48.
- Head at the placed apple, head_valid pulse -> apple_eaten high exactly one cycle, busy=1 next cycle, new valid apple within 65 cycles.
- Grid 1x1, head at (1,1) -> fallback after 64 rejections; apple=(1,1)... head there so (1,1) via grid corner rule; apple_valid at cycle 65.
- game_start concurrent with an eating head_valid -> no apple_eaten, GEN restarted.
- rst pulsed mid-GEN -> all outputs 0 same cycle, lfsr=16'hACE1 after release.
- 10000 placements at grid 64x48 -> no placement on the head, none out of range, lfsr never 0.
